bdd_tree_engine: RTL and testbench

//  Parametrised decision-tree classifier engine; successor to the fixed 8-bit single-threshold datapath.

---
 rtl/bdd_pkg.sv | 49 ++++
 rtl/bdd_node_ram.sv | 41 ++++
 rtl/bdd_tree_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_bdd_tree_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared definitions for the decision-tree classifier engine.
//   - bdd_state_t : traversal FSM states (IDLE/FETCH/EVAL/DONE)
//   - bdd_aidx_w  : attribute-index field width, never below 1 bit
//   - bdd_node_w  : node word width = AIDX_W + ATTR_W + 2*(1+CHILD_W)
//   - bdd_*_lsb   : bit positions of every node field. The node word is
//                   packed MSB->LSB as
//                   attr_idx | thresh | le_leaf | le_ptr | gt_leaf | gt_ptr
package bdd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } bdd_state_t;

  function automatic int bdd_aidx_w(input int num_attr);
    return (num_attr > 1) ? $clog2(num_attr) : 1;
  endfunction

  function automatic int bdd_node_w(input int num_attr, input int attr_w, input int child_w);
    return bdd_aidx_w(num_attr) + attr_w + 2 * (1 + child_w);
  endfunction

  function automatic int bdd_gt_ptr_lsb();
    return 0;
  endfunction

  function automatic int bdd_gt_leaf_bit(input int child_w);
    return child_w;
  endfunction

  function automatic int bdd_le_ptr_lsb(input int child_w);
    return child_w + 1;
  endfunction

  function automatic int bdd_le_leaf_bit(input int child_w);
    return 2 * child_w + 1;
  endfunction

  function automatic int bdd_thresh_lsb(input int child_w);
    return 2 * child_w + 2;
  endfunction

  function automatic int bdd_aidx_lsb(input int attr_w, input int child_w);
    return 2 * child_w + 2 + attr_w;
  endfunction

endpackage

// File: rtl/bdd_node_ram.sv
// Node table storage: DEPTH x DATA_W, one write port and one read port
// with a registered output (1-cycle read latency). The array has no reset,
// so contents survive a reset of the engine.
// Ports:
//   clk    : clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates on the next rising edge
//   raddr  : read address
//   rdata  : registered read data
module bdd_node_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bdd_tree_engine.sv
// Decision-tree classifier engine.
// Accepts an attribute vector (valid/ready), walks the node table starting
// at ROOT_ADDR at one node per two cycles (FETCH issues the RAM read, EVAL
// compares and branches), and presents the leaf class (valid/ready).
// The node table is written through the cfg port, honoured only when idle.
// Optional feature macro: BDD_DEPTH_GUARD_EN -- when defined, a traversal
// that would enter its MAX_DEPTH-th internal child is aborted with
// out_err=1 and out_class=0; when undefined, out_err is constant 0.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_attr attribute i at [i*ATTR_W +: ATTR_W]
//   out_valid/out_ready : output handshake; out_class leaf class, out_err guard abort
//   cfg_we/cfg_addr/cfg_wdata : node table write port
//   cfg_err             : 1-cycle pulse when a cfg write is dropped (engine busy)
module bdd_tree_engine
  import bdd_pkg::*;
#(
  parameter int NUM_ATTR    = 4,
  parameter int ATTR_W      = 8,
  parameter int NODE_ADDR_W = 5,
  parameter int CHILD_W     = 8,
  parameter int ROOT_ADDR   = 0,
  parameter int MAX_DEPTH   = 16,
  localparam int NODE_W     = bdd_node_w(NUM_ATTR, ATTR_W, CHILD_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ATTR*ATTR_W-1:0] in_attr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHILD_W-1:0]         out_class,
  output logic                       out_err,
  input  logic                       cfg_we,
  input  logic [NODE_ADDR_W-1:0]     cfg_addr,
  input  logic [NODE_W-1:0]          cfg_wdata,
  output logic                       cfg_err
);

  localparam int AIDX_W     = bdd_aidx_w(NUM_ATTR);
  localparam int GT_PTR_LSB = bdd_gt_ptr_lsb();
  localparam int GT_LEAF    = bdd_gt_leaf_bit(CHILD_W);
  localparam int LE_PTR_LSB = bdd_le_ptr_lsb(CHILD_W);
  localparam int LE_LEAF    = bdd_le_leaf_bit(CHILD_W);
  localparam int TH_LSB     = bdd_thresh_lsb(CHILD_W);
  localparam int AIDX_LSB   = bdd_aidx_lsb(ATTR_W, CHILD_W);

  // Parameter sanity: child pointers must be able to hold a node address.
  if (CHILD_W < NODE_ADDR_W || MAX_DEPTH < 1) begin : g_bad_params
    $error("bdd_tree_engine: CHILD_W must be >= NODE_ADDR_W and MAX_DEPTH >= 1");
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  bdd_state_t                 state_reg, state_next;
  logic [NUM_ATTR*ATTR_W-1:0] attr_reg, attr_next;
  logic [NODE_ADDR_W-1:0]     addr_reg, addr_next;
  logic                       out_valid_reg, out_valid_next;
  logic [CHILD_W-1:0]         out_class_reg, out_class_next;
  logic                       cfg_err_reg, cfg_err_next;

`ifdef BDD_DEPTH_GUARD_EN
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic [DEPTH_W-1:0] depth_inc;
  logic               out_err_reg, out_err_next;

  assign depth_inc = depth_reg + DEPTH_W'(1);
`endif

  // ---------------------------------------------------------------------
  // Node RAM: writes only while idle, read issued in FETCH
  // ---------------------------------------------------------------------
  logic              ram_we;
  logic              ram_re;
  logic [NODE_W-1:0] node_word;

  assign ram_we = cfg_we && (state_reg == IDLE);
  assign ram_re = (state_reg == FETCH);

  bdd_node_ram #(
    .ADDR_W (NODE_ADDR_W),
    .DATA_W (NODE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .re    (ram_re),
    .raddr (addr_reg),
    .rdata (node_word)
  );

  // ---------------------------------------------------------------------
  // Node decode and compare (valid during EVAL)
  // ---------------------------------------------------------------------
  logic [AIDX_W-1:0]  node_aidx;
  logic [ATTR_W-1:0]  node_thresh;
  logic               node_le_leaf;
  logic [CHILD_W-1:0] node_le_ptr;
  logic               node_gt_leaf;
  logic [CHILD_W-1:0] node_gt_ptr;

  assign node_aidx    = node_word[AIDX_LSB +: AIDX_W];
  assign node_thresh  = node_word[TH_LSB +: ATTR_W];
  assign node_le_leaf = node_word[LE_LEAF];
  assign node_le_ptr  = node_word[LE_PTR_LSB +: CHILD_W];
  assign node_gt_leaf = node_word[GT_LEAF];
  assign node_gt_ptr  = node_word[GT_PTR_LSB +: CHILD_W];

  logic [ATTR_W-1:0] attr_arr [NUM_ATTR];

  for (genvar gi = 0; gi < NUM_ATTR; gi++) begin : g_attr_split
    assign attr_arr[gi] = attr_reg[gi*ATTR_W +: ATTR_W];
  end

  // Indices with no matching attribute fall through to the default of 0.
  logic [ATTR_W-1:0] attr_val;

  always_comb begin
    attr_val = '0;
    for (int i = 0; i < NUM_ATTR; i++) begin
      if (node_aidx == AIDX_W'(i)) begin
        attr_val = attr_arr[i];
      end
    end
  end

  logic               take_le;
  logic               sel_leaf;
  logic [CHILD_W-1:0] sel_ptr;

  assign take_le  = (attr_val <= node_thresh);
  assign sel_leaf = take_le ? node_le_leaf : node_gt_leaf;
  assign sel_ptr  = take_le ? node_le_ptr : node_gt_ptr;

  // ---------------------------------------------------------------------
  // FSM next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    attr_next      = attr_reg;
    addr_next      = addr_reg;
    out_valid_next = out_valid_reg;
    out_class_next = out_class_reg;
    cfg_err_next   = cfg_we && (state_reg != IDLE);
`ifdef BDD_DEPTH_GUARD_EN
    depth_next     = depth_reg;
    out_err_next   = out_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          attr_next  = in_attr;
          addr_next  = NODE_ADDR_W'(ROOT_ADDR);
          state_next = FETCH;
`ifdef BDD_DEPTH_GUARD_EN
          depth_next = '0;
`endif
        end
      end

      FETCH: begin
        state_next = EVAL;
      end

      EVAL: begin
        if (sel_leaf) begin
          out_class_next = sel_ptr;
          out_valid_next = 1'b1;
          state_next     = DONE;
`ifdef BDD_DEPTH_GUARD_EN
          out_err_next   = 1'b0;
`endif
        end else begin
`ifdef BDD_DEPTH_GUARD_EN
          // Entering another internal node would exceed the visit budget.
          if (depth_inc == DEPTH_W'(MAX_DEPTH)) begin
            out_class_next = '0;
            out_valid_next = 1'b1;
            out_err_next   = 1'b1;
            state_next     = DONE;
          end else begin
            addr_next  = sel_ptr[NODE_ADDR_W-1:0];
            depth_next = depth_inc;
            state_next = FETCH;
          end
`else
          addr_next  = sel_ptr[NODE_ADDR_W-1:0];
          state_next = FETCH;
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
`ifdef BDD_DEPTH_GUARD_EN
          out_err_next   = 1'b0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      attr_reg      <= '0;
      addr_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_class_reg <= '0;
      cfg_err_reg   <= 1'b0;
`ifdef BDD_DEPTH_GUARD_EN
      depth_reg     <= '0;
      out_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      attr_reg      <= attr_next;
      addr_reg      <= addr_next;
      out_valid_reg <= out_valid_next;
      out_class_reg <= out_class_next;
      cfg_err_reg   <= cfg_err_next;
`ifdef BDD_DEPTH_GUARD_EN
      depth_reg     <= depth_next;
      out_err_reg   <= out_err_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_class = out_class_reg;
  assign cfg_err   = cfg_err_reg;

`ifdef BDD_DEPTH_GUARD_EN
  assign out_err = out_err_reg;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bdd_tree_engine.sv
// Self-checking bench for bdd_tree_engine (NUM_ATTR=3, ATTR_W=8,
// NODE_ADDR_W=5, CHILD_W=8, MAX_DEPTH=4). Expected results come from a
// tree-walking reference model over a shadow copy of the node table.
module tb_bdd_tree_engine;

  localparam int NA  = 3;
  localparam int AW  = 8;
  localparam int NAW = 5;
  localparam int CW  = 8;
  localparam int MD  = 4;
  localparam int NW  = 28;
`ifdef BDD_DEPTH_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NA*AW-1:0] in_attr;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_class;
  logic            out_err;
  logic            cfg_we;
  logic [NAW-1:0]  cfg_addr;
  logic [NW-1:0]   cfg_wdata;
  logic            cfg_err;

  int checks = 0;
  int errors = 0;

  logic [NW-1:0] mdl_mem [32];

  always #5 clk = ~clk;

  bdd_tree_engine #(
    .NUM_ATTR    (NA),
    .ATTR_W      (AW),
    .NODE_ADDR_W (NAW),
    .CHILD_W     (CW),
    .ROOT_ADDR   (0),
    .MAX_DEPTH   (MD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_attr   (in_attr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err)
  );

  function automatic logic [NW-1:0] pack_node(input int idx, input int th,
                                              input bit lel, input int lep,
                                              input bit gtl, input int gtp);
    return {2'(idx), 8'(th), lel, 8'(lep), gtl, 8'(gtp)};
  endfunction

  function automatic logic [NA*AW-1:0] mk_attr(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Walk the shadow table exactly as the classification rules describe.
  function automatic void model(input logic [NA*AW-1:0] a, output logic [CW-1:0] cls,
                                output int visits, output bit err);
    int addr;
    logic [NW-1:0] w;
    int idx;
    logic [7:0] th, val, ptr;
    bit leaf;
    addr = 0; cls = '0; visits = 0; err = 1'b0;
    for (int k = 0; k < 64; k++) begin
      w = mdl_mem[addr];
      idx = int'(w[27:26]);
      th = w[25:18];
      visits++;
      val = (idx < NA) ? 8'(a >> (8 * idx)) : 8'd0;
      if (val <= th) begin leaf = w[17]; ptr = w[16:9]; end
      else begin leaf = w[8]; ptr = w[7:0]; end
      if (leaf) begin cls = ptr; return; end
      if (GUARD && visits == MD) begin cls = '0; err = 1'b1; return; end
      addr = int'(ptr[4:0]);
    end
  endfunction

  task automatic write_node(input int addr, input logic [NW-1:0] w);
    cfg_we = 1'b1; cfg_addr = NAW'(addr); cfg_wdata = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl_mem[addr] = w;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_write_cfg_err addr=%0d got=%b want=0", addr, cfg_err);
    end
  endtask

  task automatic accept(input logic [NA*AW-1:0] a);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_accept got=%b want=1", in_ready);
    end
    in_valid = 1'b1; in_attr = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_attr = NA*AW'($urandom);   // must be ignored by the in-flight traversal
  endtask

  task automatic get_result(input string tag, input logic [CW-1:0] exp_cls, input bit exp_err,
                            input int exp_lat, input int hold);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout out_valid=%b want=1", tag, out_valid);
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (n !== exp_lat) begin
        errors++;
        $display("FAIL %s latency got=%0d want=%0d", tag, n, exp_lat);
      end
    end
    checks++;
    if (out_class !== exp_cls || out_err !== exp_err) begin
      errors++;
      $display("FAIL %s result class=%h err=%b want class=%h err=%b",
               tag, out_class, out_err, exp_cls, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_class !== exp_cls || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d valid=%b class=%h in_ready=%b want 1/%h/0",
                 tag, h, out_valid, out_class, in_ready, exp_cls);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_handshake valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
    end
    $display("txn %s class=%h err=%b latency=%0d", tag, out_class, out_err, n);
  endtask

  task automatic run_vec(input string tag, input logic [NA*AW-1:0] a, input int hold);
    logic [CW-1:0] c; int v; bit e;
    model(a, c, v, e);
    accept(a);
    get_result(tag, c, e, 2 * v, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 8'h00 ||
        out_err !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b cls=%h err=%b cerr=%b want 1/0/00/0/0",
               in_ready, out_valid, out_class, out_err, cfg_err);
    end
    $display("txn reset in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_single_node();
    write_node(0, pack_node(1, 8'h40, 1'b1, 8'h0A, 1'b1, 8'h0B));
    accept(mk_attr(8'hFF, 8'h40, 8'h00));
    get_result("root_le", 8'h0A, 1'b0, 2, 0);
    accept(mk_attr(8'h00, 8'h41, 8'hFF));
    get_result("root_gt", 8'h0B, 1'b0, 2, 0);
  endtask

  task automatic load_three_level();
    write_node(0, pack_node(0, 8'h80, 1'b1, 8'h11, 1'b0, 3));
    write_node(3, pack_node(2, 8'h20, 1'b1, 8'h22, 1'b0, 7));
    write_node(7, pack_node(1, 8'h10, 1'b1, 8'h33, 1'b1, 8'h5C));
  endtask

  task automatic test_three_level();
    load_three_level();
    accept(mk_attr(8'h90, 8'h50, 8'h30));
    get_result("three_level_hold", 8'h5C, 1'b0, 6, 5);
    run_vec("three_level_le", mk_attr(8'h80, 8'h00, 8'h00), 0);
  endtask

  task automatic test_cfg_busy();
    accept(mk_attr(8'h90, 8'h50, 8'h30));
    @(posedge clk); #1;                        // now in EVAL of the root
    cfg_we = 1'b1; cfg_addr = 5'd7;
    cfg_wdata = pack_node(1, 8'h10, 1'b1, 8'h99, 1'b1, 8'h99);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse got=%b want=1", cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_width got=%b want=0", cfg_err);
    end
    get_result("busy_write_inflight", 8'h5C, 1'b0, 0, 0);
    accept(mk_attr(8'h90, 8'h50, 8'h30));
    get_result("busy_write_rerun", 8'h5C, 1'b0, 6, 0);
  endtask

  task automatic test_attr_oob();
    write_node(0, pack_node(3, 8'h00, 1'b1, 8'h44, 1'b1, 8'h55));
    accept(mk_attr(8'hFF, 8'hA5, 8'h7E));
    get_result("attr_oob", 8'h44, 1'b0, 2, 0);
    // Write and accept on the same edge: traversal must use the new root.
    cfg_we = 1'b1; cfg_addr = 5'd0;
    cfg_wdata = pack_node(3, 8'h00, 1'b1, 8'h66, 1'b1, 8'h77);
    mdl_mem[0] = cfg_wdata;
    accept(mk_attr(8'h01, 8'h02, 8'h03));
    cfg_we = 1'b0;
    get_result("write_with_accept", 8'h66, 1'b0, 2, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_three_level();
    write_node(0, pack_node(0, 8'h80, 1'b1, 8'h11, 1'b0, 3));
    accept(mk_attr(8'h90, 8'h50, 8'h30));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard out_valid_seen=%b want=0", seen);
    end
    run_vec("after_reset_mid", mk_attr(8'h90, 8'h50, 8'h30), 0);
  endtask

  task automatic test_random();
    for (int a = 0; a < 32; a++) begin
      int idx, th, lep, gtp;
      bit lel, gtl;
      idx = $urandom_range(0, 3);
      th  = $urandom_range(0, 255);
      lel = (a == 31) ? 1'b1 : 1'($urandom_range(0, 1));
      gtl = (a == 31) ? 1'b1 : 1'($urandom_range(0, 1));
      // Internal children only point forward, so every random tree is acyclic.
      lep = lel ? $urandom_range(0, 255) : a + 1 + $urandom_range(0, 30 - a);
      gtp = gtl ? $urandom_range(0, 255) : a + 1 + $urandom_range(0, 30 - a);
      write_node(a, pack_node(idx, th, lel, lep, gtl, gtp));
    end
    for (int t = 0; t < 30; t++) begin
      run_vec($sformatf("random%0d", t), NA*AW'($urandom), $urandom_range(0, 2));
    end
  endtask

`ifdef BDD_DEPTH_GUARD_EN
  task automatic test_depth_guard();
    write_node(0, pack_node(0, 8'h00, 1'b1, 8'h12, 1'b0, 0));
    accept(mk_attr(8'hFF, 8'h00, 8'h00));
    get_result("depth_guard", 8'h00, 1'b1, 8, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_attr = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    test_reset();
    test_single_node();
    test_three_level();
    test_cfg_busy();
    test_attr_oob();
    test_reset_mid();
    test_random();
`ifdef BDD_DEPTH_GUARD_EN
    test_depth_guard();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
